ssd_scan_controller: RTL and testbench

- Time-multiplexing scheduler for the eight-digit seven-segment display on the Nexys4 board.
- Owns the anode and cathode pins and steps through the enabled digits in turn.
- Inserts an all-anodes-off blanking gap between digits to prevent ghosting, and applies optional leading-zero blanking.
- Game logic writes digit values through a tear-free shadow-load handshake, so the display never shows a half-updated frame.

---
 rtl/ssd_pkg.sv | 52 +++++
 rtl/ssd_hex_decoder.sv | 12 +
 rtl/ssd_scan_controller.sv | 159 +++++++++++++++
 tb/tb_ssd_scan_controller.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared types and constants for the Nexys4 eight-digit seven-segment scan controller.
package ssd_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned DIG_W      = NUM_DIGITS * NIB_W;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Frame contents latched from the game logic; only ever updated whole.
  typedef struct packed {
    logic [DIG_W-1:0]      digits;
    logic [NUM_DIGITS-1:0] en;
    logic [NUM_DIGITS-1:0] dp;
    logic                  lzb;
  } disp_cfg_t;

  // Hex-to-segment table, {a,b,c,d,e,f,g}, active-low.
  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIB_W-1:0] nib);
    logic [SEG_W-1:0] seg;
    seg = 7'b1111111;
    case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational nibble-to-cathode decoder; i_dp=1 lights the decimal point.
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [NIB_W-1:0] i_nibble,
  input  logic             i_dp,
  output logic [7:0]       o_cath_c
);

  assign o_cath_c = {hex_to_seg(i_nibble), ~i_dp};

endmodule

// File: rtl/ssd_scan_controller.sv
// Time-multiplexed scan of the Nexys4 seven-segment display with blanking gaps,
// leading-zero blanking and a frame-aligned shadow-load handshake.
module ssd_scan_controller
  import ssd_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 262144,
  parameter int unsigned BLANK_CYCLES = 4096,
  parameter int unsigned CNT_W        = 18
) (
  input  logic                  ClkPort,
  input  logic                  Reset,
  input  logic [DIG_W-1:0]      digits,
  input  logic [NUM_DIGITS-1:0] digit_en,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  input  logic                  lzb_en,
  input  logic                  load_req,
  output logic                  load_done,
  output logic [7:0]            An,
  output logic [7:0]            Cathodes,
  output logic [IDX_W-1:0]      cur_digit
);

  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  scan_state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]      r_cur, w_cur_nxt;
  logic                  r_pend, w_pend_nxt;
  disp_cfg_t             r_sh, w_sh_nxt;
  logic                  r_load_done, w_load_done_nxt;
  logic [7:0]            r_an, w_an_nxt;
  logic [7:0]            r_cath, w_cath_nxt;

  logic                  w_idle;
  logic                  w_slot_end;
  logic                  w_boundary;
  logic                  w_req;
  logic                  w_apply;
  logic [IDX_W-1:0]      w_next_idx;
  logic [IDX_W-1:0]      w_first_idx;
  logic                  w_lz_blank;
  logic [NIB_W-1:0]      w_cur_nib;
  logic [7:0]            w_dec_cath;

  assign w_idle     = (r_sh.en == '0);
  assign w_slot_end = (r_cnt == SLOT_LAST);
  assign w_cur_nib  = r_sh.digits[{r_cur, 2'b00} +: NIB_W];

  ssd_hex_decoder u_dec (
    .i_nibble (w_cur_nib),
    .i_dp     (r_sh.dp[r_cur]),
    .o_cath_c (w_dec_cath)
  );

  // Rotating search for the next enabled digit above r_cur; k=8 lands on r_cur itself.
  always_comb begin
    w_next_idx = r_cur;
    for (int k = int'(NUM_DIGITS); k >= 1; k--) begin
      if (r_sh.en[r_cur + IDX_W'(k)]) begin
        w_next_idx = r_cur + IDX_W'(k);
      end
    end
  end

  // Lowest enabled digit of the incoming enable mask, used when a load lands.
  always_comb begin
    w_first_idx = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      if (digit_en[i]) begin
        w_first_idx = IDX_W'(i);
      end
    end
  end

  // Current digit is a leading zero if nothing enabled at or above it is non-zero.
  always_comb begin
    w_lz_blank = r_sh.lzb && (r_cur != '0);
    for (int j = 0; j < int'(NUM_DIGITS); j++) begin
      if ((IDX_W'(j) >= r_cur) && r_sh.en[j] &&
          (r_sh.digits[j*int'(NIB_W) +: NIB_W] != '0)) begin
        w_lz_blank = 1'b0;
      end
    end
  end

  assign w_boundary = w_slot_end && !w_idle && (w_next_idx <= r_cur);
  assign w_req      = r_pend | load_req;
  assign w_apply    = w_req && (w_idle || w_boundary);

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_cur_nxt       = r_cur;
    w_pend_nxt      = r_pend;
    w_sh_nxt        = r_sh;
    w_load_done_nxt = 1'b0;
    w_an_nxt        = AN_OFF;
    w_cath_nxt      = r_cath;

    if ((r_state == DRIVE) && !w_idle) begin
      w_cath_nxt = w_dec_cath;
      if (!w_lz_blank) begin
        w_an_nxt = ~(NUM_DIGITS'(1) << r_cur);
      end
    end

    if (w_apply) begin
      w_sh_nxt        = '{digits: digits, en: digit_en, dp: dp_mask, lzb: lzb_en};
      w_cur_nxt       = w_first_idx;
      w_cnt_nxt       = '0;
      w_state_nxt     = BLANK;
      w_pend_nxt      = 1'b0;
      w_load_done_nxt = 1'b1;
    end else begin
      w_pend_nxt = w_req;
      if (w_idle) begin
        w_cnt_nxt   = '0;
        w_state_nxt = BLANK;
      end else if (w_slot_end) begin
        w_cnt_nxt   = '0;
        w_cur_nxt   = w_next_idx;
        w_state_nxt = BLANK;
      end else begin
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_state_nxt = (r_cnt >= BLANK_LAST) ? DRIVE : BLANK;
      end
    end
  end

  always_ff @(posedge ClkPort) begin
    if (Reset) begin
      r_state     <= BLANK;
      r_cnt       <= '0;
      r_cur       <= '0;
      r_pend      <= 1'b0;
      r_sh        <= '0;
      r_load_done <= 1'b0;
      r_an        <= AN_OFF;
      r_cath      <= SEG_OFF;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cur       <= w_cur_nxt;
      r_pend      <= w_pend_nxt;
      r_sh        <= w_sh_nxt;
      r_load_done <= w_load_done_nxt;
      r_an        <= w_an_nxt;
      r_cath      <= w_cath_nxt;
    end
  end

  assign load_done = r_load_done;
  assign An        = r_an;
  assign Cathodes  = r_cath;
  assign cur_digit = r_cur;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Self-checking bench for ssd_scan_controller: directed scenarios then random loads,
// every cycle compared against a slot-level behavioural model.
module tb_ssd_scan_controller;

  localparam int unsigned SCAN_DIV     = 8;
  localparam int unsigned BLANK_CYCLES = 2;
  localparam int unsigned CNT_W        = 3;

  logic        ClkPort = 1'b0;
  logic        Reset;
  logic [31:0] digits;
  logic [7:0]  digit_en;
  logic [7:0]  dp_mask;
  logic        lzb_en;
  logic        load_req;
  logic        load_done;
  logic [7:0]  An;
  logic [7:0]  Cathodes;
  logic [2:0]  cur_digit;

  int errors = 0;
  int checks = 0;
  int ld_seen = 0;

  // Model: which digit's slot we are in, how far into it, and the latched frame.
  int          m_cur, m_pos;
  logic [31:0] m_dig;
  logic [7:0]  m_en, m_dp;
  logic        m_lzb, m_pend, m_ld;
  logic [7:0]  m_an, m_cath;

  ssd_scan_controller #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .ClkPort   (ClkPort),
    .Reset     (Reset),
    .digits    (digits),
    .digit_en  (digit_en),
    .dp_mask   (dp_mask),
    .lzb_en    (lzb_en),
    .load_req  (load_req),
    .load_done (load_done),
    .An        (An),
    .Cathodes  (Cathodes),
    .cur_digit (cur_digit)
  );

  always #5 ClkPort = ~ClkPort;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0000001;  4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;  4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;  4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;  4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;  4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;  default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] nib_of(input logic [31:0] d, input int i);
    return 4'((d >> (4 * i)) & 32'hF);
  endfunction

  function automatic int next_en(input int cur, input logic [7:0] en);
    for (int k = 1; k <= 8; k++) begin
      if (en[(cur + k) % 8]) return (cur + k) % 8;
    end
    return cur;
  endfunction

  function automatic int lowest_en(input logic [7:0] en);
    for (int i = 0; i < 8; i++) begin
      if (en[i]) return i;
    end
    return 0;
  endfunction

  function automatic bit lz_blanked(input int i);
    if (!m_lzb || i == 0) return 1'b0;
    for (int j = i; j < 8; j++) begin
      if (m_en[j] && nib_of(m_dig, j) != 4'h0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic       idle, last, boundary, req;
    int         nxt;
    logic [7:0] an_n, cath_n;
    if (Reset) begin
      m_cur = 0; m_pos = 0; m_dig = '0; m_en = '0; m_dp = '0; m_lzb = 1'b0;
      m_pend = 1'b0; m_ld = 1'b0; m_an = 8'hFF; m_cath = 8'hFF;
      return;
    end
    idle   = (m_en == 8'h00);
    an_n   = 8'hFF;
    cath_n = m_cath;
    if (!idle && m_pos >= int'(BLANK_CYCLES)) begin
      cath_n = {seg_of(nib_of(m_dig, m_cur)), ~m_dp[m_cur]};
      if (!lz_blanked(m_cur)) an_n[m_cur] = 1'b0;
    end
    req      = m_pend || load_req;
    last     = (m_pos == int'(SCAN_DIV) - 1);
    nxt      = next_en(m_cur, m_en);
    boundary = !idle && last && (nxt <= m_cur);
    m_ld     = 1'b0;
    if (req && (idle || boundary)) begin
      m_dig = digits; m_en = digit_en; m_dp = dp_mask; m_lzb = lzb_en;
      m_cur = lowest_en(digit_en); m_pos = 0; m_pend = 1'b0; m_ld = 1'b1;
    end else begin
      m_pend = req;
      if (idle) m_pos = 0;
      else if (last) begin m_pos = 0; m_cur = nxt; end
      else m_pos++;
    end
    m_an   = an_n;
    m_cath = cath_n;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at t=%0t: observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at t=%0t: observed=%0d expected=%0d", tag, $time, obs, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge ClkPort);
    #1;
    chk("An", An, m_an);
    chk("Cathodes", Cathodes, m_cath);
    chk("cur_digit", {5'b0, cur_digit}, 8'(m_cur));
    chk("load_done", {7'b0, load_done}, {7'b0, m_ld});
    if (load_done === 1'b1) ld_seen++;
  endtask

  task automatic pulse_load(input logic [31:0] d, input logic [7:0] en,
                            input logic [7:0] dp, input logic lz);
    digits = d; digit_en = en; dp_mask = dp; lzb_en = lz;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic wait_ld(input string tag, input int budget);
    int n;
    n = 0;
    while (load_done !== 1'b1 && n < budget) begin tick(); n++; end
    chk(tag, {7'b0, load_done}, 8'h01);
  endtask

  task automatic wait_digit(input string tag, input logic [2:0] d, input int budget);
    int n;
    n = 0;
    while (cur_digit !== d && n < budget) begin tick(); n++; end
    chk(tag, {5'b0, cur_digit}, {5'b0, d});
  endtask

  initial begin
    int         seq[$];
    int         exp_seq[6];
    int         prev, cnt_a, cnt_b, ld_base;
    logic [7:0] r_en;

    Reset = 1'b1; digits = '0; digit_en = '0; dp_mask = '0; lzb_en = 1'b0; load_req = 1'b0;
    tick();
    Reset = 1'b0;
    chk("rst_An", An, 8'hFF);
    chk("rst_Cathodes", Cathodes, 8'hFF);
    tick();
    tick();

    // Digits 0,1,7 enabled: slot order 0 -> 1 -> 7 -> 0.
    pulse_load(32'h0000_0042, 8'h83, 8'h00, 1'b0);
    chk("s1_load_done", {7'b0, load_done}, 8'h01);
    prev = int'(cur_digit);
    for (int i = 0; i < 48; i++) begin
      tick();
      if (int'(cur_digit) != prev) begin prev = int'(cur_digit); seq.push_back(prev); end
    end
    exp_seq = '{1, 7, 0, 1, 7, 0};
    chk_int("s1_slot_count", seq.size(), 6);
    for (int i = 0; i < 6 && i < seq.size(); i++) chk_int("s1_slot_seq", seq[i], exp_seq[i]);

    // Leading-zero blanking: only digit 0 lights, for 6 drive cycles per 32-cycle frame.
    pulse_load(32'h0000_0007, 8'h0F, 8'h00, 1'b1);
    wait_ld("s2_load", 40);
    cnt_a = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (An !== 8'hFF) cnt_a++;
    end
    chk_int("s2_lit_cycles", cnt_a, 6);

    // Loads requested mid-frame land at the wrap to digit 0, with a single done pulse.
    wait_digit("s3_reach_d1", 3'd1, 40);
    ld_base = ld_seen;
    pulse_load(32'h0000_1234, 8'h0F, 8'h00, 1'b0);
    tick();
    tick();
    pulse_load(32'h0000_1234, 8'h0F, 8'h00, 1'b0);
    wait_ld("s3_load", 40);
    chk("s3_digit_after_load", {5'b0, cur_digit}, 8'h00);
    for (int i = 0; i < 40; i++) tick();
    chk_int("s3_done_pulses", ld_seen - ld_base, 1);

    // Decimal point of digit 1 only.
    pulse_load(32'h0000_1234, 8'h0F, 8'h02, 1'b0);
    wait_ld("s5_load", 40);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (An !== 8'hFF && Cathodes[0] === 1'b0) cnt_a++;
      if (An !== 8'hFF && An !== 8'hFD && Cathodes[0] === 1'b0) cnt_b++;
    end
    chk_int("s5_dp_d1_cycles", cnt_a, 6);
    chk_int("s5_dp_other_cycles", cnt_b, 0);

    // Empty enable mask freezes the scan; next load is taken immediately.
    pulse_load(32'h0, 8'h00, 8'h00, 1'b0);
    wait_ld("s4_load_off", 40);
    for (int i = 0; i < 20; i++) tick();
    chk("s4_dark", An, 8'hFF);
    pulse_load(32'h0005_0000, 8'h10, 8'h00, 1'b0);
    chk("s4_idle_load_done", {7'b0, load_done}, 8'h01);
    chk("s4_idle_digit", {5'b0, cur_digit}, 8'h04);
    for (int i = 0; i < 24; i++) tick();
    pulse_load(32'h0009_0000, 8'h10, 8'h00, 1'b0);
    wait_ld("s4_single_digit_boundary", 9);

    // Reset mid-DRIVE of digit 2 with a load pending discards the load.
    pulse_load(32'h0000_5678, 8'h0F, 8'h00, 1'b0);
    wait_ld("s6_load", 12);
    wait_digit("s6_reach_d2", 3'd2, 40);
    for (int i = 0; i < 4; i++) tick();
    pulse_load(32'h1111_1111, 8'hFF, 8'h00, 1'b0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("s6_An", An, 8'hFF);
    chk("s6_Cathodes", Cathodes, 8'hFF);
    chk("s6_cur_digit", {5'b0, cur_digit}, 8'h00);
    ld_base = ld_seen;
    for (int i = 0; i < 30; i++) tick();
    chk_int("s6_no_done", ld_seen - ld_base, 0);
    chk("s6_still_dark", An, 8'hFF);

    // Random loads, masks and occasional resets.
    for (int i = 0; i < 900; i++) begin
      digits = $urandom >> (4 * $urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       r_en = 8'h00;
        1:       r_en = 8'(1) << $urandom_range(0, 7);
        default: r_en = 8'($urandom);
      endcase
      digit_en = r_en;
      dp_mask  = 8'($urandom);
      lzb_en   = 1'($urandom);
      load_req = ($urandom_range(0, 11) == 0);
      Reset    = ($urandom_range(0, 299) == 0);
      tick();
    end
    Reset = 1'b0; load_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
